// File: rtl/ff_cfg_pkg.sv
// Shared types and constants for the slice storage-cell configuration sequencer.
package ff_cfg_pkg;

    // Sequencer states; outputs are decoded from these alone.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_GSR   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Each cell consumes FIELD_W consecutive frame bits, in this order.
    localparam int FIELD_W       = 4;
    localparam int FLD_SYNCASYNC = 0;
    localparam int FLD_FFLAT     = 1;
    localparam int FLD_INIT      = 2;
    localparam int FLD_SRHILO    = 3;

endpackage

// File: rtl/ff_cfg_shift_reg.sv
// LSB-first serial-to-parallel shift register with a running XOR parity.
// After W shifts the first bit shifted in sits at data[0]. The parity
// accumulator has its own enable so a trailing parity bit can be folded
// into the check without disturbing the data word.
module ff_cfg_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         par_en,
    input  logic         bit_in,
    output logic [W-1:0] data,
    output logic         parity
);

    // Shift new bits in at the top so the earliest bit ends up at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            data   <= '0;
            parity <= 1'b0;
        end else begin
            if (shift_en) begin
                data <= {bit_in, data[W-1:1]};
            end
            if (par_en) begin
                parity <= parity ^ bit_in;
            end
        end
    end

endmodule

// File: rtl/ff_cfg_startup_seq.sv
// Configuration and startup sequencer for a bank of slice storage cells.
// Handshake: a configuration bit transfers on any rising edge where
// cfg_valid and cfg_ready are both high; cfg_ready is high only in LOAD,
// and a low cfg_valid simply stalls the frame with no timeout.
// Frame: 4*NUM_FF data bits LSB first, then one even-parity bit.
module ff_cfg_startup_seq
    import ff_cfg_pkg::*;
#(
    parameter int NUM_FF     = 8,
    parameter int GSR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [NUM_FF-1:0] syncasync_01,
    output logic [NUM_FF-1:0] fflat_01,
    output logic [NUM_FF-1:0] init01,
    output logic [NUM_FF-1:0] srhilo,
    output logic              gsr,
    output logic              gce,
    output logic              done,
    output logic              err
);

    localparam int DATA_W = FIELD_W * NUM_FF;
    localparam int CNT_W  = $clog2(DATA_W + 2);
    localparam int GSR_W  = (GSR_CYCLES > 1) ? $clog2(GSR_CYCLES + 1) : 1;

    // Index of the parity bit within the frame.
    localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(DATA_W);
    // GSR counter counts down to zero; zero marks the last GSR cycle.
    localparam logic [GSR_W-1:0] GSR_LOAD = GSR_W'(GSR_CYCLES - 1);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GSR_W-1:0]   gsr_cnt;
    logic [DATA_W-1:0]  shadow;
    logic               par_acc;
    logic               clr;
    logic               commit;
    logic               accept;
    logic               shift_en;

    assign accept   = cfg_ready && cfg_valid;
    assign shift_en = accept && (bit_cnt < PAR_IDX);

    ff_cfg_shift_reg #(
        .W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .par_en   (accept),
        .bit_in   (cfg_bit),
        .data     (shadow),
        .parity   (par_acc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and outputs decoded from the registered state.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        commit    = 1'b0;
        cfg_ready = 1'b0;
        gsr       = 1'b1;
        gce       = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    clr       = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (bit_cnt == PAR_IDX)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!par_acc) begin
                    commit    = 1'b1;
                    state_nxt = ST_GSR;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_GSR: begin
                if (gsr_cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                gsr  = 1'b0;
                gce  = 1'b1;
                done = 1'b1;
                if (cfg_start) begin
                    clr       = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_ERR: begin
                err = 1'b1;
                if (cfg_start) begin
                    clr       = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame bit counter and GSR hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            gsr_cnt <= '0;
        end else begin
            if (clr) begin
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (commit) begin
                gsr_cnt <= GSR_LOAD;
            end else if ((state == ST_GSR) && (gsr_cnt != '0)) begin
                gsr_cnt <= gsr_cnt - 1'b1;
            end
        end
    end

    // Commit the shadow frame to the cell mode buses; only done while gsr is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncasync_01 <= '0;
            fflat_01     <= '0;
            init01       <= '0;
            srhilo       <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_FF; i++) begin
                syncasync_01[i] <= shadow[FIELD_W*i + FLD_SYNCASYNC];
                fflat_01[i]     <= shadow[FIELD_W*i + FLD_FFLAT];
                init01[i]       <= shadow[FIELD_W*i + FLD_INIT];
                srhilo[i]       <= shadow[FIELD_W*i + FLD_SRHILO];
            end
        end
    end

endmodule

// File: tb/tb_ff_cfg_startup_seq.sv
// Directed bench for ff_cfg_startup_seq with NUM_FF=2, GSR_CYCLES=4.
module tb_ff_cfg_startup_seq;

    localparam int N = 2;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_start = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [N-1:0] syncasync_01;
    logic [N-1:0] fflat_01;
    logic [N-1:0] init01;
    logic [N-1:0] srhilo;
    logic         gsr;
    logic         gce;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    logic [1:0] cur_s = 2'b00;
    logic [1:0] cur_f = 2'b00;
    logic [1:0] cur_i = 2'b00;
    logic [1:0] cur_r = 2'b00;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       gap;
        logic       exp_err;
        logic [1:0] s;
        logic [1:0] f;
        logic [1:0] i;
        logic [1:0] r;
    } vec_t;

    vec_t vecs[7];

    ff_cfg_startup_seq #(
        .NUM_FF     (N),
        .GSR_CYCLES (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_bit      (cfg_bit),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .syncasync_01 (syncasync_01),
        .fflat_01     (fflat_01),
        .init01       (init01),
        .srhilo       (srhilo),
        .gsr          (gsr),
        .gce          (gce),
        .done         (done),
        .err          (err)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_buses(input string tag, input logic [1:0] s, input logic [1:0] f,
                             input logic [1:0] i, input logic [1:0] r);
        chk($sformatf("%s_syncasync", tag), 32'(syncasync_01), 32'(s));
        chk($sformatf("%s_fflat", tag), 32'(fflat_01), 32'(f));
        chk($sformatf("%s_init", tag), 32'(init01), 32'(i));
        chk($sformatf("%s_srhilo", tag), 32'(srhilo), 32'(r));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s_gsr", tag), 32'(gsr), 32'd1);
        chk($sformatf("%s_gce", tag), 32'(gce), 32'd0);
        chk($sformatf("%s_done", tag), 32'(done), 32'd0);
        chk($sformatf("%s_err", tag), 32'(err), 32'd0);
        chk($sformatf("%s_ready", tag), 32'(cfg_ready), 32'd0);
        chk_buses(tag, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    // Drive one full frame from IDLE/DONE/ERR and check the whole commit sequence.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk($sformatf("v%0d_entry_ready", idx), 32'(cfg_ready), 32'd1);
        chk($sformatf("v%0d_entry_gsr", idx), 32'(gsr), 32'd1);
        chk($sformatf("v%0d_entry_gce", idx), 32'(gce), 32'd0);
        chk($sformatf("v%0d_entry_done", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_entry_err", idx), 32'(err), 32'd0);
        chk_buses($sformatf("v%0d_entry_held", idx), cur_s, cur_f, cur_i, cur_r);
        for (int k = 0; k < 9; k++) begin
            if (v.gap) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom_range(0, 1));
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
                chk($sformatf("v%0d_stall_ready", idx), 32'(cfg_ready), 32'd1);
            end
            cfg_valid = 1'b1;
            cfg_bit   = (k < 8) ? v.data[k] : v.par;
            tick();
        end
        cfg_valid = 1'b0;
        chk($sformatf("v%0d_check_ready", idx), 32'(cfg_ready), 32'd0);
        chk_buses($sformatf("v%0d_check_held", idx), cur_s, cur_f, cur_i, cur_r);
        tick();
        if (v.exp_err) begin
            chk($sformatf("v%0d_err", idx), 32'(err), 32'd1);
            chk($sformatf("v%0d_err_gsr", idx), 32'(gsr), 32'd1);
            chk($sformatf("v%0d_err_gce", idx), 32'(gce), 32'd0);
            chk($sformatf("v%0d_err_done", idx), 32'(done), 32'd0);
            chk_buses($sformatf("v%0d_err_held", idx), v.s, v.f, v.i, v.r);
            cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            chk($sformatf("v%0d_err_stays", idx), 32'(err), 32'd1);
            chk($sformatf("v%0d_err_noready", idx), 32'(cfg_ready), 32'd0);
        end else begin
            chk_buses($sformatf("v%0d_commit", idx), v.s, v.f, v.i, v.r);
            n = 0;
            if (v.gap) cfg_start = 1'b1;
            for (int c = 0; c < 20 && gsr; c++) begin
                chk($sformatf("v%0d_gce_during_gsr", idx), 32'(gce), 32'd0);
                n++;
                tick();
                cfg_start = 1'b0;
            end
            cfg_start = 1'b0;
            chk($sformatf("v%0d_gsr_len", idx), 32'(n), 32'(G));
            chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d_gce", idx), 32'(gce), 32'd1);
            chk($sformatf("v%0d_done_err", idx), 32'(err), 32'd0);
            tick();
            chk($sformatf("v%0d_done_gsr", idx), 32'(gsr), 32'd0);
            chk_buses($sformatf("v%0d_done_stable", idx), v.s, v.f, v.i, v.r);
        end
        cur_s = v.s;
        cur_f = v.f;
        cur_i = v.i;
        cur_r = v.r;
    endtask

    initial begin
        // data bits are listed MSB..LSB; bit k is the k-th bit sent.
        vecs[0] = '{8'b0100_1101, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b01};
        vecs[1] = '{8'b0100_1101, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 2'b01};
        vecs[2] = '{8'b0100_1101, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b11, 2'b01};
        vecs[3] = '{8'b1111_1111, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11};
        vecs[4] = '{8'b0000_0000, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11};
        vecs[5] = '{8'b1000_0010, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10};
        vecs[6] = '{8'b0000_0001, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};

        // Reset state, including a cfg_valid in IDLE that must not be taken.
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        chk_reset_vals("idle");

        for (int v = 0; v < 7; v++) begin
            run_vec(v, vecs[v]);
        end

        // Asynchronous reset five bits into a frame.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midload_rst");
        rst = 1'b0;
        tick();
        chk_reset_vals("after_rst");
        cur_s = 2'b00;
        cur_f = 2'b00;
        cur_i = 2'b00;
        cur_r = 2'b00;
        run_vec(7, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
